motor_pwm_drv: RTL



---
 rtl/motor_pkg.sv | 15 +
 rtl/motor_cmd_buf.sv | 72 +++++++
 rtl/motor_pwm_drv.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/motor_pkg.sv
// Shared definitions for the motor PWM driver.
//   motor_state_t : FSM state encoding, also exported on state_o for debug
//   DIR_FWD/REV   : direction command encoding (0 = forward leg, 1 = reverse leg)
package motor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } motor_state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/motor_cmd_buf.sv
// Double-buffered duty/direction command store.
//   load/duty_in/dir_in : capture a new command into the pending slot (duty saturated to PERIOD)
//   apply_req           : an application opportunity from the FSM; copies pending -> active if pending
//   pending             : a command is waiting to be applied
//   dir_pend            : direction of the waiting command
//   duty_act/dir_act    : command currently driving the bridge
//   cmd_ack             : one-cycle pulse, registered, when a pending command becomes active
module motor_cmd_buf
    import motor_pkg::*;
#(
    parameter int PERIOD = 1000,
    parameter int DUTY_W = $clog2(PERIOD + 1)
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              load,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic              dir_in,
    input  logic              apply_req,
    output logic              pending,
    output logic              dir_pend,
    output logic [DUTY_W-1:0] duty_act,
    output logic              dir_act,
    output logic              cmd_ack
);

    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PERIOD);

    logic [DUTY_W-1:0] duty_pend_reg;
    logic              dir_pend_reg;
    logic              pending_reg;
    logic [DUTY_W-1:0] duty_act_reg;
    logic              dir_act_reg;
    logic              cmd_ack_reg;
    logic [DUTY_W-1:0] duty_sat;
    logic              do_apply;

    assign duty_sat = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
    assign do_apply = apply_req && pending_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            duty_pend_reg <= '0;
            dir_pend_reg  <= DIR_FWD;
            pending_reg   <= 1'b0;
            duty_act_reg  <= '0;
            dir_act_reg   <= DIR_FWD;
            cmd_ack_reg   <= 1'b0;
        end else begin
            cmd_ack_reg <= do_apply;
            if (do_apply) begin
                duty_act_reg <= duty_pend_reg;
                dir_act_reg  <= dir_pend_reg;
                pending_reg  <= 1'b0;
            end
            // Placed after the apply so a coinciding load keeps pending set:
            // the old pending value goes active, the new one waits.
            if (load) begin
                duty_pend_reg <= duty_sat;
                dir_pend_reg  <= dir_in;
                pending_reg   <= 1'b1;
            end
        end
    end

    assign pending  = pending_reg;
    assign dir_pend = dir_pend_reg;
    assign duty_act = duty_act_reg;
    assign dir_act  = dir_act_reg;
    assign cmd_ack  = cmd_ack_reg;

endmodule

// File: rtl/motor_pwm_drv.sv
// Tick-enabled H-bridge PWM driver with dead time on direction reversal.
//   clk, rst      : clock, synchronous active-high reset
//   tick          : time-base enable; the period counter only moves on tick
//   en            : driver enable; low sends the FSM to IDLE and the outputs low
//   load/duty_in/dir_in : command strobe, applied only at period boundaries
//   pwm_a/pwm_b   : forward / reverse leg drive (registered, never both high)
//   period_start  : one-cycle pulse when a new period begins
//   cmd_ack       : one-cycle pulse when a pending command becomes active
//   state_o       : current FSM state (debug)
module motor_pwm_drv
    import motor_pkg::*;
#(
    parameter int PERIOD     = 1000,
    parameter int DEAD_TICKS = 50,
    parameter int DUTY_W     = $clog2(PERIOD + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              en,
    input  logic              load,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic              dir_in,
    output logic              pwm_a,
    output logic              pwm_b,
    output logic              period_start,
    output logic              cmd_ack,
    output logic [1:0]        state_o
);

    localparam int CNT_W  = $clog2(PERIOD);
    localparam int DEAD_W = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'((DEAD_TICKS > 0) ? DEAD_TICKS - 1 : 0);
    localparam logic HAS_DEAD = (DEAD_TICKS > 0);

    motor_state_t      state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DEAD_W-1:0] dead_cnt_reg, dead_cnt_next;
    logic              period_start_reg, period_start_next;
    logic              pwm_a_reg, pwm_b_reg;
    logic              apply_req;
    logic              on_now;
    logic [1:0]        leg_next;

    logic              pending;
    logic              dir_pend;
    logic [DUTY_W-1:0] duty_act;
    logic              dir_act;

    motor_cmd_buf #(
        .PERIOD (PERIOD),
        .DUTY_W (DUTY_W)
    ) u_cmd_buf (
        .clk       (clk),
        .srst      (rst),
        .load      (load),
        .duty_in   (duty_in),
        .dir_in    (dir_in),
        .apply_req (apply_req),
        .pending   (pending),
        .dir_pend  (dir_pend),
        .duty_act  (duty_act),
        .dir_act   (dir_act),
        .cmd_ack   (cmd_ack)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            dead_cnt_reg     <= '0;
            period_start_reg <= 1'b0;
            pwm_a_reg        <= 1'b0;
            pwm_b_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            dead_cnt_reg     <= dead_cnt_next;
            period_start_reg <= period_start_next;
            pwm_a_reg        <= leg_next[0];
            pwm_b_reg        <= leg_next[1];
        end
    end

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        dead_cnt_next     = dead_cnt_reg;
        period_start_next = 1'b0;
        apply_req         = 1'b0;
        if (!en) begin
            state_next    = ST_IDLE;
            cnt_next      = '0;
            dead_cnt_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Enabling never inserts dead time: outputs were already low.
                    apply_req         = 1'b1;
                    state_next        = ST_RUN;
                    cnt_next          = '0;
                    period_start_next = 1'b1;
                end
                ST_RUN: begin
                    if (tick) begin
                        if (cnt_reg == CNT_LAST) begin
                            cnt_next = '0;
                            // A reversal while a leg is actually conducting must pass
                            // through DEAD; the command is held until DEAD exits.
                            if (HAS_DEAD && pending && (dir_pend != dir_act) && (duty_act != '0)) begin
                                state_next    = ST_DEAD;
                                dead_cnt_next = '0;
                            end else begin
                                apply_req         = 1'b1;
                                period_start_next = 1'b1;
                            end
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end
                ST_DEAD: begin
                    if (tick) begin
                        if (dead_cnt_reg == DEAD_LAST) begin
                            apply_req         = 1'b1;
                            state_next        = ST_RUN;
                            cnt_next          = '0;
                            period_start_next = 1'b1;
                        end else begin
                            dead_cnt_next = dead_cnt_reg + DEAD_W'(1);
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // en is folded in so dropping it forces the outputs low on the very next clock.
    assign on_now = en && (state_reg == ST_RUN) && (DUTY_W'(cnt_reg) < duty_act);

    // Each leg conducts only when the active direction selects it, so both
    // legs can never be high together.
    for (genvar gi = 0; gi < 2; gi++) begin : g_leg
        assign leg_next[gi] = on_now && (dir_act == ((gi == 0) ? DIR_FWD : DIR_REV));
    end

    assign pwm_a        = pwm_a_reg;
    assign pwm_b        = pwm_b_reg;
    assign period_start = period_start_reg;
    assign state_o      = state_reg;

endmodule
